score_counter: RTL

Per-player point counter sitting directly upstream of `Scoreboard`. Detects goal events from the ball/collision logic, keeps the player's 8-bit binary score, and drives `Scoreboard`'s `binary` and `update` inputs. Update strobes are paced so `Scoreboard` always finishes one conversion before the next starts. Also flags end of game when the winning score is reached.

---
 rtl/score_counter_if.sv | 22 ++
 rtl/score_counter.sv | 95 +++++++++
 2 files changed

// File: rtl/score_counter_if.sv
// score_counter_if: goal/new_game inputs and Scoreboard-facing outputs of score_counter
//
// Signals:
//   goal       level from ball logic, high while the ball is in this player's goal zone
//   new_game   single-cycle pulse that clears the score and game_over
//   binary     current score, connects to Scoreboard.binary
//   update     single-cycle strobe, connects to Scoreboard.update
//   game_over  high while binary equals the winning score
//
// Modports: master drives goal/new_game (ball logic or bench), slave is score_counter.
interface score_counter_if #(
    parameter int SCORE_WIDTH = 8
);
    logic                   goal;
    logic                   new_game;
    logic [SCORE_WIDTH-1:0] binary;
    logic                   update;
    logic                   game_over;

    modport master (output goal, new_game, input binary, update, game_over);
    modport slave  (input goal, new_game, output binary, update, game_over);
endinterface

// File: rtl/score_counter.sv
// score_counter: per-player goal counter feeding Scoreboard with paced update strobes
//
// Ports:
//   clock    system clock, all logic on the rising edge
//   reset_n  asynchronous active-low reset
//   sc       score_counter_if.slave: goal, new_game in; binary, update, game_over out
//
// Build option GOAL_SYNC_EN: when defined, goal passes through a two-flop
// synchronizer before edge detection (goal-to-binary 3 edges, goal-to-update 4).
// Left undefined, goal must come from logic on the same clock.
module score_counter #(
    parameter int SCORE_WIDTH = 8,
    parameter int WIN_SCORE   = 11,
    parameter int HOLDOFF     = 16
) (
    input logic            clock,
    input logic            reset_n,
    score_counter_if.slave sc
);
    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic                   goal_s;
    logic                   goal_d;
    logic                   rise;
    logic                   score_event;
    logic                   take;
    logic [SCORE_WIDTH-1:0] next_score;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [CW-1:0]          gap_cnt;
    logic                   pending;

`ifdef GOAL_SYNC_EN
    logic [1:0] goal_sync;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) goal_sync <= '0;
        else goal_sync <= {goal_sync[0], sc.goal};
    end
    assign goal_s = goal_sync[1];
`else
    assign goal_s = sc.goal;
`endif

    assign rise        = goal_s & ~goal_d;
    assign next_score  = sc.binary + SCORE_WIDTH'(1);
    // new_game also needs a display refresh, so it counts as an event
    assign score_event = sc.new_game | (rise & ~sc.game_over);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            goal_d       <= 1'b0;
            sc.binary    <= '0;
            sc.game_over <= 1'b0;
        end else begin
            goal_d <= goal_s;
            if (sc.new_game) begin
                sc.binary    <= '0;
                sc.game_over <= 1'b0;
            end else if (rise && !sc.game_over) begin
                sc.binary    <= next_score;
                sc.game_over <= next_score == SCORE_WIDTH'(WIN_SCORE);
            end
        end
    end

    // A pulse may only start from IDLE or once the holdoff gap has fully elapsed
    always_comb begin
        state_nxt = (state == IDLE)                     ? (pending ? PULSE : IDLE) :
                    (state == PULSE)                    ? GAP :
                    (state == GAP && gap_cnt != '0)     ? GAP :
                    (state == GAP)                      ? (pending ? PULSE : IDLE) :
                                                          IDLE;
    end

    assign take = state_nxt == PULSE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            pending   <= 1'b1;
            sc.update <= 1'b0;
        end else begin
            state     <= state_nxt;
            sc.update <= take;
            // an event on the same edge as a pulse launch must survive for the next pulse
            pending   <= score_event | (pending & ~take);
            if (state == PULSE) gap_cnt <= CW'(HOLDOFF - 1);
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - CW'(1);
        end
    end
endmodule
